// File: rtl/div_iter_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// EX drives operands and the start/annul handshake; the divider returns {remainder, quotient}.
interface div_iter_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock on operand magnitudes,
// with sign fix-up applied as the result is registered. Result is {remainder, quotient}.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    div_iter_if.slave       bus
);
    localparam int                 CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [DATA_W-1:0]      rem_r, rem_s;
    logic [DATA_W-1:0]      quo_r, quo_s;
    logic [DATA_W-1:0]      dvsr_r, dvsr_s;
    logic                   sign1_r, sign1_s;
    logic                   sign2_r, sign2_s;
    logic [2*DATA_W-1:0]    result_r, result_s;
    logic                   ready_r, ready_s;

    logic [DATA_W:0]        rem_sh_s;
    logic                   ge_s;
    logic [DATA_W-1:0]      diff_s;
    logic [DATA_W-1:0]      rem_nx_s;
    logic [DATA_W-1:0]      quo_nx_s;
    logic                   sign1_in_s;
    logic                   sign2_in_s;

    // Two's complement negation when en is set; MIN maps to itself, which is its unsigned magnitude.
    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
        logic [DATA_W-1:0] r;
        if (en) begin
            r = ~v + DATA_W'(1'b1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // The partial remainder is always below the divisor, so one extra bit holds the shifted value
    // and the low DATA_W bits of the difference are exact whenever the subtraction is taken.
    assign rem_sh_s   = {rem_r, quo_r[DATA_W-1]};
    assign ge_s       = (rem_sh_s >= {1'b0, dvsr_r});
    assign diff_s     = rem_sh_s[DATA_W-1:0] - dvsr_r;
    assign rem_nx_s   = ge_s ? diff_s : rem_sh_s[DATA_W-1:0];
    assign quo_nx_s   = {quo_r[DATA_W-2:0], ge_s};
    assign sign1_in_s = bus.opdata1_i[DATA_W-1] & bus.signed_div_i;
    assign sign2_in_s = bus.opdata2_i[DATA_W-1] & bus.signed_div_i;

    // Next-state and datapath update for the divider FSM.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rem_s    = rem_r;
        quo_s    = quo_r;
        dvsr_s   = dvsr_r;
        sign1_s  = sign1_r;
        sign2_s  = sign2_r;
        result_s = result_r;
        ready_s  = ready_r;

        case (state_r)
            ST_IDLE: begin
                result_s = {(2*DATA_W){1'b0}};
                ready_s  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    sign1_s = sign1_in_s;
                    sign2_s = sign2_in_s;
                    quo_s   = neg_if(bus.opdata1_i, sign1_in_s);
                    dvsr_s  = neg_if(bus.opdata2_i, sign2_in_s);
                    rem_s   = {DATA_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    if (bus.opdata2_i == {DATA_W{1'b0}}) begin
                        state_s = ST_BYZERO;
                    end else begin
                        state_s = ST_ON;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_BYZERO: begin
                result_s = {(2*DATA_W){1'b0}};
                if (bus.annul_i) begin
                    state_s = ST_IDLE;
                    ready_s = 1'b0;
                end else begin
                    state_s = ST_END;
                    ready_s = 1'b1;
                end
            end

            ST_ON: begin
                if (bus.annul_i) begin
                    state_s  = ST_IDLE;
                    result_s = {(2*DATA_W){1'b0}};
                    ready_s  = 1'b0;
                end else begin
                    rem_s = rem_nx_s;
                    quo_s = quo_nx_s;
                    cnt_s = cnt_r + CNT_W'(1'b1);
                    if (cnt_r == LAST_CNT) begin
                        // Remainder follows the dividend's sign; quotient is negative on differing signs.
                        state_s  = ST_END;
                        result_s = {neg_if(rem_nx_s, sign1_r), neg_if(quo_nx_s, sign1_r ^ sign2_r)};
                        ready_s  = 1'b1;
                    end else begin
                        state_s = ST_ON;
                        ready_s = 1'b0;
                    end
                end
            end

            ST_END: begin
                if (!bus.start_i) begin
                    state_s  = ST_IDLE;
                    result_s = {(2*DATA_W){1'b0}};
                    ready_s  = 1'b0;
                end else begin
                    state_s = ST_END;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                result_s = {(2*DATA_W){1'b0}};
                ready_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= {DATA_W{1'b0}};
            quo_r    <= {DATA_W{1'b0}};
            dvsr_r   <= {DATA_W{1'b0}};
            sign1_r  <= 1'b0;
            sign2_r  <= 1'b0;
            result_r <= {(2*DATA_W){1'b0}};
            ready_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rem_r    <= rem_s;
            quo_r    <= quo_s;
            dvsr_r   <= dvsr_s;
            sign1_r  <= sign1_s;
            sign2_r  <= sign2_s;
            result_r <= result_s;
            ready_r  <= ready_s;
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a 32-bit and an 8-bit instance checked against hand-computed
// quotients/remainders, latency, divide-by-zero, annul, reset and back-to-back handshakes.
module tb_div_iter;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    div_iter_if #(.DATA_W(32)) bus32 ();
    div_iter_if #(.DATA_W(8))  bus8 ();

    div_iter #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    div_iter #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    // Issue a 32-bit request at the next edge; edges counts from the accept edge (inclusive)
    // to the first edge after which ready_o is seen, or equals limit if it never rises.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int limit, output int edges);
        @(negedge clk);
        bus32.signed_div_i = sgn;
        bus32.opdata1_i    = a;
        bus32.opdata2_i    = b;
        bus32.start_i      = 1'b1;
        bus32.annul_i      = 1'b0;
        edges = limit;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) begin
                bus32.opdata1_i = ~a;
                bus32.opdata2_i = a ^ b ^ 32'h5A5A_1234;
            end
            if (bus32.ready_o === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic drop_start32();
        bus32.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0; bus32.signed_div_i = 1'b0;
        bus32.opdata1_i = 32'd0; bus32.opdata2_i = 32'd0;
        bus8.start_i = 1'b0; bus8.annul_i = 1'b0; bus8.signed_div_i = 1'b0;
        bus8.opdata1_i = 8'd0; bus8.opdata2_i = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset32 ready=%b result=%h expected ready=0 result=0", bus32.ready_o, bus32.result_o);
        end
        checks++;
        if (bus8.ready_o !== 1'b0 || bus8.result_o !== 16'd0) begin
            failures++;
            $display("FAIL reset8 ready=%b result=%h expected ready=0 result=0", bus8.ready_o, bus8.result_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_divide();
        vec_t v[8];
        int   edges;
        v[0] = '{1'b0, 32'd100,       32'd7,        32'h0000_000E, 32'h0000_0002};
        v[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        v[2] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
        v[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        v[4] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        v[5] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE};
        v[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'h0000_0000};
        v[7] = '{1'b0, 32'd5,         32'd9,        32'h0000_0000, 32'h0000_0005};
        for (int k = 0; k < 8; k++) begin
            run_div(v[k].sgn, v[k].a, v[k].b, 40, edges);
            checks++;
            if (edges != 33) begin
                failures++;
                $display("FAIL latency vec%0d edges=%0d expected 33", k, edges);
            end
            checks++;
            if (bus32.result_o !== {v[k].r, v[k].q}) begin
                failures++;
                $display("FAIL result vec%0d got=%h expected=%h", k, bus32.result_o, {v[k].r, v[k].q});
            end
            drop_start32();
            checks++;
            if (bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
                failures++;
                $display("FAIL drop vec%0d ready=%b result=%h expected 0/0", k, bus32.ready_o, bus32.result_o);
            end
        end
    endtask

    task automatic test_div_zero();
        int edges;
        run_div(1'b0, 32'd5, 32'd0, 40, edges);
        checks++;
        if (edges != 2 || bus32.result_o !== 64'd0) begin
            failures++;
            $display("FAIL divzero_u edges=%0d result=%h expected edges=2 result=0", edges, bus32.result_o);
        end
        drop_start32();
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 40, edges);
        checks++;
        if (edges != 2 || bus32.result_o !== 64'd0) begin
            failures++;
            $display("FAIL divzero_s edges=%0d result=%h expected edges=2 result=0", edges, bus32.result_o);
        end
        drop_start32();
        // annul while waiting in the divide-by-zero state
        bus32.opdata1_i = 32'd5; bus32.opdata2_i = 32'd0; bus32.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.annul_i = 1'b1; bus32.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus32.annul_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus32.ready_o !== 1'b0) begin
            failures++;
            $display("FAIL divzero_annul ready=%b expected 0", bus32.ready_o);
        end
    endtask

    task automatic test_annul();
        int   edges;
        logic seen = 1'b0;
        @(negedge clk);
        bus32.signed_div_i = 1'b0; bus32.opdata1_i = 32'd100; bus32.opdata2_i = 32'd7;
        bus32.start_i = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus32.annul_i = 1'b1; bus32.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus32.annul_i = 1'b0;
        checks++;
        if (bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
            failures++;
            $display("FAIL annul_now ready=%b result=%h expected 0/0", bus32.ready_o, bus32.result_o);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus32.ready_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL annul_quiet ready_seen=%b expected 0", seen);
        end
        run_div(1'b0, 32'd9, 32'd3, 40, edges);
        checks++;
        if (edges != 33 || bus32.result_o !== {32'd0, 32'd3}) begin
            failures++;
            $display("FAIL annul_next edges=%0d result=%h expected 33 / %h", edges, bus32.result_o, {32'd0, 32'd3});
        end
        drop_start32();
    endtask

    task automatic test_reset_mid();
        int edges;
        @(negedge clk);
        bus32.signed_div_i = 1'b0; bus32.opdata1_i = 32'd100; bus32.opdata2_i = 32'd7;
        bus32.start_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_on ready=%b result=%h expected 0/0", bus32.ready_o, bus32.result_o);
        end
        rst = 1'b0; bus32.start_i = 1'b0;
        run_div(1'b0, 32'd50, 32'd5, 40, edges);
        checks++;
        if (edges != 33 || bus32.result_o !== {32'd0, 32'd10}) begin
            failures++;
            $display("FAIL reset_after edges=%0d result=%h expected 33 / %h", edges, bus32.result_o, {32'd0, 32'd10});
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_end ready=%b result=%h expected 0/0", bus32.ready_o, bus32.result_o);
        end
        rst = 1'b0;
        drop_start32();
    endtask

    task automatic test_back_to_back();
        int edges;
        run_div(1'b0, 32'd1000, 32'd10, 40, edges);
        checks++;
        if (edges != 33 || bus32.result_o !== {32'd0, 32'd100}) begin
            failures++;
            $display("FAIL b2b_first edges=%0d result=%h expected 33 / %h", edges, bus32.result_o, {32'd0, 32'd100});
        end
        for (int i = 0; i < 3; i++) begin
            bus32.annul_i = (i == 1);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus32.ready_o !== 1'b1 || bus32.result_o !== {32'd0, 32'd100}) begin
                failures++;
                $display("FAIL b2b_hold%0d ready=%b result=%h expected 1 / %h", i, bus32.ready_o, bus32.result_o, {32'd0, 32'd100});
            end
        end
        bus32.annul_i = 1'b0;
        drop_start32();
        checks++;
        if (bus32.ready_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drop ready=%b expected 0", bus32.ready_o);
        end
        run_div(1'b1, 32'hFFFF_FC18, 32'd10, 40, edges);
        checks++;
        if (edges != 33 || bus32.result_o !== {32'd0, 32'hFFFF_FF9C}) begin
            failures++;
            $display("FAIL b2b_second edges=%0d result=%h expected 33 / %h", edges, bus32.result_o, {32'd0, 32'hFFFF_FF9C});
        end
        drop_start32();
    endtask

    task automatic test_width8();
        logic       sg[2];
        logic [7:0] a[2], b[2];
        logic [15:0] exp_res[2];
        int         edges;
        sg[0] = 1'b0; a[0] = 8'd200; b[0] = 8'd3;   exp_res[0] = {8'd2, 8'd66};
        sg[1] = 1'b1; a[1] = 8'h80;  b[1] = 8'hFF;  exp_res[1] = {8'h00, 8'h80};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus8.signed_div_i = sg[k]; bus8.opdata1_i = a[k]; bus8.opdata2_i = b[k];
            bus8.start_i = 1'b1;
            edges = 16;
            for (int i = 1; i <= 16; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (i == 1) begin
                    bus8.opdata1_i = 8'd17; bus8.opdata2_i = 8'd0;
                end
                if (bus8.ready_o === 1'b1) begin
                    edges = i;
                    break;
                end
            end
            checks++;
            if (edges != 9 || bus8.result_o !== exp_res[k]) begin
                failures++;
                $display("FAIL w8_vec%0d edges=%0d result=%h expected 9 / %h", k, edges, bus8.result_o, exp_res[k]);
            end
            bus8.start_i = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus8.ready_o !== 1'b0 || bus8.result_o !== 16'd0) begin
                failures++;
                $display("FAIL w8_drop%0d ready=%b result=%h expected 0/0", k, bus8.ready_o, bus8.result_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider serving DIV/DIVU in the EX stage.
- Generalised in operand width. Supports signed and unsigned modes, annul (flush) and divide-by-zero.
- EX holds start_i high and stalls the pipeline until ready_o. The result feeds HI (remainder) and LO (quotient) through the normal hilo write path.

Parameters:
- DATA_W, 32, operand width in bits; must be >= 2. Counter width is derived internally as clog2(DATA_W+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1'b1).
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request; EX holds it high until it has consumed ready_o.
- annul_i  in  1  cancel request (branch flush / exception).
- result_o  out  2*DATA_W  {remainder, quotient}; registered.
- ready_o  out  1  result valid; registered.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, result_o=0, ready_o=0, internal counter/datapath=0. Reset takes priority in every state, including mid-division.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 at edge E0 accepts the request; otherwise the state stays IDLE.
  - On accept, if opdata2_i==0 -> BYZERO; else -> ON.
  - On accept, capture the operands. In signed mode, convert negative operands to magnitude (two's complement). Latch sign1 = opdata1_i[MSB] & signed_div_i and sign2 = opdata2_i[MSB] & signed_div_i. Counter=0.
  - Operand changes after E0 are ignored.
- ON:
  - Each edge performs one restoring iteration: shift {rem, dividend} left by 1; if rem_shifted >= divisor then subtract and set quotient bit to 1; counter++.
  - annul_i=1 at any ON edge -> IDLE; result_o and ready_o stay 0.
  - After DATA_W iterations (edges E1..E_DATA_W) -> END. On the same edge, result_o and ready_o=1 are registered. ready_o is therefore visible DATA_W+1 edges after E0.
- BYZERO: next edge (E1) -> END with result_o=0 and ready_o=1, unless annul_i=1, which sends the state to IDLE.
- END:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0 at an edge -> IDLE, ready_o=0, result_o=0.
  - annul_i is ignored in END; the result already delivered is EX's responsibility.
- Sign fix-up, applied when leaving ON:
  - Quotient is negated if sign1^sign2.
  - Remainder is negated if sign1, so the remainder takes the dividend's sign.
  - Unsigned mode applies no fix-up.
- Overflow case (signed, MIN / -1): quotient = MIN (two's complement wrap), remainder = 0. No trap.
- Back-to-back requests: a new request cannot be accepted in the cycle start_i drops. After END -> IDLE, the next start_i is sampled no earlier than the following edge.
- ready_o is never asserted in IDLE, BYZERO or ON.

Test Plan (DATA_W=32 unless stated):
- Unsigned 100 / 7, start held -> ready_o rises 33 edges after accept; result_o = {32'h2, 32'hE}. Drop start -> IDLE next edge, ready_o=0.
- Signed -7 / 2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF. Signed 7 / -2 -> quotient 32'hFFFFFFFD, remainder 32'h1.
- Signed 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0. The same operands unsigned -> quotient 0, remainder 32'h80000000.
- Divisor 0 (any mode) -> ready_o at 2nd edge after accept, result_o=0.
- annul_i pulsed at iteration 10 -> IDLE next edge, ready_o never asserts. A new 9/3 request then completes with {0, 3}.
- rst asserted mid-ON -> all outputs 0 on that edge, state IDLE. DATA_W=8 instance, unsigned 200/3 -> {8'd2, 8'd66} after 9 edges.
